// File: rtl/atm_controller_param.sv
// ATM session controller. It accepts a card, collects an N_DIGITOS BCD PIN,
// counts wrong attempts up to a lockout, and then processes any number of
// deposits and withdrawals per card session. Withdrawals are limited by the
// balance and by a cumulative per-session limit. Idle sessions time out.
// ESTADO_DBG exposes the FSM state, encoded as:
// 0 ESPERA_TARJETA, 1 ESPERA_PIN, 2 VERIFICA, 3 ESPERA_MONTO, 4 PROCESA, 5 BLOQUEADO.
// Strobes: DIGITO_STB and MONTO_STB are one-cycle qualifiers. They are acted on
// only in the state that consumes them. There is no back-pressure, so a strobe
// that arrives in any other state is dropped.
module atm_controller_param #(
    parameter int N_DIGITOS       = 4,
    parameter int MAX_INTENTOS    = 3,
    parameter int ANCHO_MONTO     = 32,
    parameter int ANCHO_BALANCE   = 64,
    parameter int BALANCE_INICIAL = 0,
    parameter int LIMITE_RETIRO   = 1000,
    parameter int TIMEOUT_CICLOS  = 1000
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               TARJETA_RECIBIDA,
    input  logic [4*N_DIGITOS-1:0]             PIN,
    input  logic [3:0]                         DIGITO,
    input  logic                               DIGITO_STB,
    input  logic                               TIPO_TRANS,
    input  logic [ANCHO_MONTO-1:0]             MONTO,
    input  logic                               MONTO_STB,
    output logic [ANCHO_BALANCE-1:0]           BALANCE,
    output logic [$clog2(MAX_INTENTOS+1)-1:0]  INTENTOS_RESTANTES,
    output logic                               BALANCE_ACTUALIZADO,
    output logic                               ENTREGAR_DINERO,
    output logic                               FONDOS_INSUFICIENTES,
    output logic                               LIMITE_EXCEDIDO,
    output logic                               PIN_INCORRECTO,
    output logic                               TIEMPO_AGOTADO,
    output logic                               ADVERTENCIA,
    output logic                               BLOQUEO,
    output logic [2:0]                         ESTADO_DBG
);

    localparam int FW = $clog2(MAX_INTENTOS + 1);
    localparam int CW = $clog2(N_DIGITOS + 1);
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam int DW = 4 * N_DIGITOS;
    localparam logic [ANCHO_BALANCE:0]   LIMITE_EXT = (ANCHO_BALANCE + 1)'(LIMITE_RETIRO);
    localparam logic [ANCHO_BALANCE-1:0] BAL_INI    = ANCHO_BALANCE'(BALANCE_INICIAL);

    typedef enum logic [2:0] {
        ESPERA_TARJETA = 3'd0,
        ESPERA_PIN     = 3'd1,
        VERIFICA       = 3'd2,
        ESPERA_MONTO   = 3'd3,
        PROCESA        = 3'd4,
        BLOQUEADO      = 3'd5
    } estado_t;

    estado_t                  state_q, state_d;
    logic [ANCHO_BALANCE-1:0] balance_q, balance_d;
    logic [FW-1:0]            fallos_q, fallos_d;
    logic [DW-1:0]            digitos_q, digitos_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [ANCHO_BALANCE-1:0] retirado_q, retirado_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [ANCHO_MONTO-1:0]   monto_q, monto_d;
    logic                     tipo_q, tipo_d;
    logic act_q, act_d, ent_q, ent_d, fondos_q, fondos_d, lim_q, lim_d;
    logic pinbad_q, pinbad_d, tiempo_q, tiempo_d;
    logic advert_q, bloqueo_q;
    logic [FW-1:0]            intentos_q;

    // Amounts are compared and summed one bit wider than the balance so that
    // saturation and the session-limit check cannot wrap.
    logic [ANCHO_BALANCE-1:0] monto_ext;
    logic [ANCHO_BALANCE:0]   suma;
    logic [ANCHO_BALANCE:0]   total_ret;

    assign monto_ext = ANCHO_BALANCE'(monto_q);
    assign suma      = {1'b0, balance_q} + {1'b0, monto_ext};
    assign total_ret = {1'b0, retirado_q} + {1'b0, monto_ext};

    // Next-state and pulse decode; card removal outranks strobes, strobes outrank timeout.
    always_comb begin
        state_d    = state_q;
        balance_d  = balance_q;
        fallos_d   = fallos_q;
        digitos_d  = digitos_q;
        cnt_d      = cnt_q;
        retirado_d = retirado_q;
        timer_d    = timer_q;
        monto_d    = monto_q;
        tipo_d     = tipo_q;
        act_d      = 1'b0;
        ent_d      = 1'b0;
        fondos_d   = 1'b0;
        lim_d      = 1'b0;
        pinbad_d   = 1'b0;
        tiempo_d   = 1'b0;
        case (state_q)
            ESPERA_TARJETA: begin
                digitos_d  = '0;
                cnt_d      = '0;
                timer_d    = '0;
                retirado_d = '0;
                if (TARJETA_RECIBIDA) state_d = ESPERA_PIN;
            end
            ESPERA_PIN: begin
                if (!TARJETA_RECIBIDA) begin
                    state_d = ESPERA_TARJETA;
                    timer_d = '0;
                end else if (DIGITO_STB) begin
                    digitos_d = (digitos_q << 4) | DW'(DIGITO);
                    timer_d   = '0;
                    if (cnt_q == CW'(N_DIGITOS - 1)) begin
                        cnt_d   = '0;
                        state_d = VERIFICA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (timer_q == TW'(TIMEOUT_CICLOS - 1)) begin
                    tiempo_d = 1'b1;
                    timer_d  = '0;
                    state_d  = ESPERA_TARJETA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            VERIFICA: begin
                timer_d = '0;
                if (!TARJETA_RECIBIDA) begin
                    state_d = ESPERA_TARJETA;
                end else if (digitos_q == PIN) begin
                    fallos_d = '0;
                    state_d  = ESPERA_MONTO;
                end else begin
                    fallos_d = fallos_q + FW'(1);
                    pinbad_d = 1'b1;
                    if (fallos_q == FW'(MAX_INTENTOS - 1)) begin
                        state_d = BLOQUEADO;
                    end else begin
                        digitos_d = '0;
                        cnt_d     = '0;
                        state_d   = ESPERA_PIN;
                    end
                end
            end
            ESPERA_MONTO: begin
                if (!TARJETA_RECIBIDA) begin
                    state_d = ESPERA_TARJETA;
                    timer_d = '0;
                end else if (MONTO_STB) begin
                    monto_d = MONTO;
                    tipo_d  = TIPO_TRANS;
                    timer_d = '0;
                    state_d = PROCESA;
                end else if (timer_q == TW'(TIMEOUT_CICLOS - 1)) begin
                    tiempo_d = 1'b1;
                    timer_d  = '0;
                    state_d  = ESPERA_TARJETA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            PROCESA: begin
                timer_d = '0;
                state_d = TARJETA_RECIBIDA ? ESPERA_MONTO : ESPERA_TARJETA;
                if (!tipo_q) begin
                    balance_d = suma[ANCHO_BALANCE] ? '1 : suma[ANCHO_BALANCE-1:0];
                    act_d     = 1'b1;
                end else if (monto_ext > balance_q) begin
                    fondos_d = 1'b1;
                end else if (total_ret > LIMITE_EXT) begin
                    lim_d = 1'b1;
                end else begin
                    balance_d  = balance_q - monto_ext;
                    retirado_d = total_ret[ANCHO_BALANCE-1:0];
                    act_d      = 1'b1;
                    ent_d      = 1'b1;
                end
            end
            BLOQUEADO: begin
                state_d = BLOQUEADO;
            end
            default: begin
                state_d = ESPERA_TARJETA;
            end
        endcase
    end

    // State, datapath and registered outputs; RESET wins over every state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ESPERA_TARJETA;
            balance_q  <= BAL_INI;
            fallos_q   <= '0;
            digitos_q  <= '0;
            cnt_q      <= '0;
            retirado_q <= '0;
            timer_q    <= '0;
            monto_q    <= '0;
            tipo_q     <= 1'b0;
            act_q      <= 1'b0;
            ent_q      <= 1'b0;
            fondos_q   <= 1'b0;
            lim_q      <= 1'b0;
            pinbad_q   <= 1'b0;
            tiempo_q   <= 1'b0;
            advert_q   <= 1'b0;
            bloqueo_q  <= 1'b0;
            intentos_q <= FW'(MAX_INTENTOS);
        end else begin
            state_q    <= state_d;
            balance_q  <= balance_d;
            fallos_q   <= fallos_d;
            digitos_q  <= digitos_d;
            cnt_q      <= cnt_d;
            retirado_q <= retirado_d;
            timer_q    <= timer_d;
            monto_q    <= monto_d;
            tipo_q     <= tipo_d;
            act_q      <= act_d;
            ent_q      <= ent_d;
            fondos_q   <= fondos_d;
            lim_q      <= lim_d;
            pinbad_q   <= pinbad_d;
            tiempo_q   <= tiempo_d;
            advert_q   <= (fallos_d == FW'(MAX_INTENTOS - 1));
            bloqueo_q  <= (state_d == BLOQUEADO);
            intentos_q <= FW'(MAX_INTENTOS) - fallos_d;
        end
    end

    assign BALANCE              = balance_q;
    assign INTENTOS_RESTANTES   = intentos_q;
    assign BALANCE_ACTUALIZADO  = act_q;
    assign ENTREGAR_DINERO      = ent_q;
    assign FONDOS_INSUFICIENTES = fondos_q;
    assign LIMITE_EXCEDIDO      = lim_q;
    assign PIN_INCORRECTO       = pinbad_q;
    assign TIEMPO_AGOTADO       = tiempo_q;
    assign ADVERTENCIA          = advert_q;
    assign BLOQUEO              = bloqueo_q;
    assign ESTADO_DBG           = state_q;

endmodule

// File: tb/tb_atm_controller_param.sv
// Bench for atm_controller_param: reset checks, a transaction table, hand-written
// corner sequences (lockout, timeout, card removal, reset in PROCESA) and
// randomized sessions checked against a session-level reference model.
module tb_atm_controller_param;

    localparam int          BAL_INI = 1000;
    localparam int          LIMITE  = 500;
    localparam int          TMO     = 20;
    localparam logic [15:0] PIN_OK  = 16'h1234;

    // Pulse vector layout: {act, entregar, fondos, limite, pin_incorrecto, tiempo}
    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_DEP  = 6'b100000;
    localparam logic [5:0] P_RET  = 6'b110000;
    localparam logic [5:0] P_FOND = 6'b001000;
    localparam logic [5:0] P_LIM  = 6'b000100;

    localparam logic [2:0] S_TARJ = 3'd0, S_PIN = 3'd1, S_MONTO = 3'd3, S_BLOQ = 3'd5;

    logic        CLK, RESET, TARJETA_RECIBIDA, DIGITO_STB, TIPO_TRANS, MONTO_STB;
    logic [15:0] PIN;
    logic [3:0]  DIGITO;
    logic [31:0] MONTO;
    logic [63:0] BALANCE;
    logic [1:0]  INTENTOS_RESTANTES;
    logic BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, LIMITE_EXCEDIDO;
    logic PIN_INCORRECTO, TIEMPO_AGOTADO, ADVERTENCIA, BLOQUEO;
    logic [2:0]  ESTADO_DBG;

    atm_controller_param #(
        .N_DIGITOS(4), .MAX_INTENTOS(3), .ANCHO_MONTO(32), .ANCHO_BALANCE(64),
        .BALANCE_INICIAL(BAL_INI), .LIMITE_RETIRO(LIMITE), .TIMEOUT_CICLOS(TMO)
    ) dut (
        .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .PIN(PIN),
        .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .TIPO_TRANS(TIPO_TRANS),
        .MONTO(MONTO), .MONTO_STB(MONTO_STB), .BALANCE(BALANCE),
        .INTENTOS_RESTANTES(INTENTOS_RESTANTES),
        .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO), .ENTREGAR_DINERO(ENTREGAR_DINERO),
        .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES), .LIMITE_EXCEDIDO(LIMITE_EXCEDIDO),
        .PIN_INCORRECTO(PIN_INCORRECTO), .TIEMPO_AGOTADO(TIEMPO_AGOTADO),
        .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO), .ESTADO_DBG(ESTADO_DBG)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;
    logic [69:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    function automatic logic [5:0] pulses();
        return {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
                LIMITE_EXCEDIDO, PIN_INCORRECTO, TIEMPO_AGOTADO};
    endfunction

    // ---------------- reference model ----------------
    logic [63:0] m_bal;
    logic [63:0] m_sess;
    int          m_fails;

    function automatic logic [69:0] model_txn(input logic tipo, input logic [31:0] monto);
        logic [5:0]  f;
        logic [63:0] amt;
        amt = 64'(monto);
        if (!tipo) begin
            f     = P_DEP;
            m_bal = (amt > ~m_bal) ? '1 : m_bal + amt;
        end else if (amt > m_bal) begin
            f = P_FOND;
        end else if (m_sess + amt > 64'(LIMITE)) begin
            f = P_LIM;
        end else begin
            f      = P_RET;
            m_bal  = m_bal - amt;
            m_sess = m_sess + amt;
        end
        return {f, m_bal};
    endfunction

    function automatic logic [15:0] wrong_pin();
        logic [15:0] p;
        p = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if (p == PIN_OK) p[3:0] = 4'h5;
        return p;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1; TARJETA_RECIBIDA = 1'b0; DIGITO_STB = 1'b0; MONTO_STB = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic insert_card();
        @(negedge CLK);
        TARJETA_RECIBIDA = 1'b1;
        @(negedge CLK);
    endtask

    task automatic remove_card();
        @(negedge CLK);
        TARJETA_RECIBIDA = 1'b0;
        @(negedge CLK);
        check("remove_state", 64'(ESTADO_DBG), 64'(S_TARJ));
    endtask

    // Four back-to-back strobes, then wait through VERIFICA; returns after its edge.
    task automatic enter_pin(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) begin
            @(negedge CLK);
            DIGITO = p[i*4 +: 4];
            DIGITO_STB = 1'b1;
        end
        @(negedge CLK);
        DIGITO_STB = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_txn(input logic tipo, input logic [31:0] monto,
                          output logic [5:0] p, output logic [63:0] bal);
        @(negedge CLK);
        TIPO_TRANS = tipo; MONTO = monto; MONTO_STB = 1'b1;
        @(negedge CLK);
        MONTO_STB = 1'b0;
        @(negedge CLK);
        p   = pulses();
        bal = BALANCE;
    endtask

    task automatic open_session();
        if (TARJETA_RECIBIDA) remove_card();
        insert_card();
        enter_pin(PIN_OK);
        check("open_state", 64'(ESTADO_DBG), 64'(S_MONTO));
        check("open_pinbad", 64'(PIN_INCORRECTO), 64'(0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        new_sess;
        logic        tipo;
        logic [31:0] monto;
        logic [5:0]  exp_p;
        logic [63:0] exp_bal;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [5:0]  p;
        logic [63:0] bal;
        logic [69:0] e;
        logic        good;
        logic [2:0]  exp_state;
        int          k;

        vecs[0]  = '{1'b1, 1'b1, 32'd1500, P_FOND, 64'd1000};
        vecs[1]  = '{1'b0, 1'b0, 32'd250,  P_DEP,  64'd1250};
        vecs[2]  = '{1'b1, 1'b1, 32'd300,  P_RET,  64'd950};
        vecs[3]  = '{1'b0, 1'b1, 32'd300,  P_LIM,  64'd950};
        vecs[4]  = '{1'b1, 1'b1, 32'd300,  P_RET,  64'd650};
        vecs[5]  = '{1'b0, 1'b1, 32'd2000, P_FOND, 64'd650};
        vecs[6]  = '{1'b0, 1'b0, 32'd0,    P_DEP,  64'd650};
        vecs[7]  = '{1'b0, 1'b1, 32'd200,  P_RET,  64'd450};
        vecs[8]  = '{1'b0, 1'b1, 32'd1,    P_LIM,  64'd450};
        vecs[9]  = '{1'b1, 1'b1, 32'd451,  P_FOND, 64'd450};
        vecs[10] = '{1'b0, 1'b1, 32'd450,  P_RET,  64'd0};
        vecs[11] = '{1'b0, 1'b0, 32'd5,    P_DEP,  64'd5};

        RESET = 1'b1; TARJETA_RECIBIDA = 1'b0; PIN = PIN_OK; DIGITO = '0;
        DIGITO_STB = 1'b0; TIPO_TRANS = 1'b0; MONTO = '0; MONTO_STB = 1'b0;
        repeat (3) @(negedge CLK);

        // reset state
        check("rst_state", 64'(ESTADO_DBG), 64'(S_TARJ));
        check("rst_balance", BALANCE, 64'(BAL_INI));
        check("rst_intentos", 64'(INTENTOS_RESTANTES), 64'(3));
        check("rst_pulses", 64'(pulses()), 64'(P_NONE));
        check("rst_levels", 64'({ADVERTENCIA, BLOQUEO}), 64'(0));
        RESET = 1'b0;

        // table of transactions
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].new_sess) open_session();
            do_txn(vecs[i].tipo, vecs[i].monto, p, bal);
            check($sformatf("vec%0d_pulses", i), 64'(p), 64'(vecs[i].exp_p));
            check($sformatf("vec%0d_balance", i), bal, vecs[i].exp_bal);
        end
        remove_card();

        // lockout after three wrong PINs; balance retained; reset restores
        do_reset();
        open_session();
        do_txn(1'b0, 32'd77, p, bal);
        check("lock_pre_balance", bal, 64'd1077);
        remove_card();
        insert_card();
        for (int i = 1; i <= 3; i++) begin
            enter_pin(16'h1235);
            check($sformatf("lock_pinbad%0d", i), 64'(PIN_INCORRECTO), 64'(1));
            check($sformatf("lock_intentos%0d", i), 64'(INTENTOS_RESTANTES), 64'(3 - i));
            check($sformatf("lock_adv%0d", i), 64'(ADVERTENCIA), 64'(i == 2));
            check($sformatf("lock_bloq%0d", i), 64'(BLOQUEO), 64'(i == 3));
            check($sformatf("lock_state%0d", i), 64'(ESTADO_DBG), 64'(i == 3 ? S_BLOQ : S_PIN));
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            check("lock_quiet", 64'({pulses(), BLOQUEO, ESTADO_DBG}), 64'({P_NONE, 1'b1, S_BLOQ}));
            check("lock_balance", BALANCE, 64'd1077);
            TARJETA_RECIBIDA = 1'($urandom_range(0, 1));
            DIGITO_STB = 1'($urandom_range(0, 1));
            DIGITO = 4'($urandom_range(0, 9));
            MONTO_STB = 1'($urandom_range(0, 1));
            TIPO_TRANS = 1'($urandom_range(0, 1));
            MONTO = 32'($urandom_range(0, 100));
        end
        DIGITO_STB = 1'b0; MONTO_STB = 1'b0;
        do_reset();
        check("unlock_bloq", 64'(BLOQUEO), 64'(0));
        check("unlock_balance", BALANCE, 64'(BAL_INI));
        check("unlock_intentos", 64'(INTENTOS_RESTANTES), 64'(3));

        // inactivity timeout during PIN entry
        insert_card();
        @(negedge CLK); DIGITO = 4'd1; DIGITO_STB = 1'b1;
        @(negedge CLK); DIGITO = 4'd2;
        @(negedge CLK); DIGITO_STB = 1'b0;
        k = 0;
        while (k < 40 && !TIEMPO_AGOTADO) begin
            @(negedge CLK);
            k++;
        end
        check("tmo_cycles", 64'(k), 64'(TMO));
        check("tmo_state", 64'(ESTADO_DBG), 64'(S_TARJ));
        check("tmo_intentos", 64'(INTENTOS_RESTANTES), 64'(3));
        @(negedge CLK);
        check("tmo_one_cycle", 64'(TIEMPO_AGOTADO), 64'(0));
        remove_card();
        open_session();

        // card removed together with the last digit strobe
        remove_card();
        insert_card();
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK); DIGITO = 4'(i); DIGITO_STB = 1'b1;
        end
        @(negedge CLK); DIGITO = 4'd5; TARJETA_RECIBIDA = 1'b0;
        @(negedge CLK); DIGITO_STB = 1'b0;
        check("rm_state", 64'(ESTADO_DBG), 64'(S_TARJ));
        check("rm_pinbad_a", 64'(PIN_INCORRECTO), 64'(0));
        @(negedge CLK);
        check("rm_pinbad_b", 64'(PIN_INCORRECTO), 64'(0));
        check("rm_intentos", 64'(INTENTOS_RESTANTES), 64'(3));

        // RESET while in PROCESA
        open_session();
        do_txn(1'b0, 32'd50, p, bal);
        check("rstp_pre_balance", bal, 64'd1050);
        @(negedge CLK); TIPO_TRANS = 1'b0; MONTO = 32'd100; MONTO_STB = 1'b1;
        @(negedge CLK); MONTO_STB = 1'b0; RESET = 1'b1; TARJETA_RECIBIDA = 1'b0;
        @(negedge CLK);
        check("rstp_pulses", 64'(pulses()), 64'(P_NONE));
        check("rstp_balance", BALANCE, 64'(BAL_INI));
        check("rstp_state", 64'(ESTADO_DBG), 64'(S_TARJ));
        RESET = 1'b0;

        // randomized sessions against the model
        m_bal = 64'(BAL_INI); m_sess = '0; m_fails = 0;
        for (int s = 0; s < 40; s++) begin
            insert_card();
            m_sess = '0;
            good = ($urandom_range(0, 3) != 0);
            enter_pin(good ? PIN_OK : wrong_pin());
            if (good) begin
                m_fails = 0;
                exp_state = S_MONTO;
            end else begin
                m_fails++;
                exp_state = (m_fails == 3) ? S_BLOQ : S_PIN;
            end
            check("rnd_pinbad", 64'(PIN_INCORRECTO), 64'(!good));
            check("rnd_state", 64'(ESTADO_DBG), 64'(exp_state));
            check("rnd_intentos", 64'(INTENTOS_RESTANTES), 64'(3 - m_fails));
            check("rnd_adv", 64'(ADVERTENCIA), 64'(m_fails == 2));
            check("rnd_bloq", 64'(BLOQUEO), 64'(m_fails == 3));
            if (m_fails == 3) begin
                do_reset();
                m_bal = 64'(BAL_INI);
                m_fails = 0;
            end else if (good) begin
                for (int t = $urandom_range(1, 5); t > 0; t--) begin
                    logic        tp;
                    logic [31:0] mt;
                    tp = 1'($urandom_range(0, 1));
                    mt = tp ? 32'($urandom_range(1, 700)) : 32'($urandom_range(0, 400));
                    exp_q.push_back(model_txn(tp, mt));
                    do_txn(tp, mt, p, bal);
                    e = exp_q.pop_front();
                    check("rnd_pulses", 64'(p), 64'(e[69:64]));
                    check("rnd_balance", bal, e[63:0]);
                end
                remove_card();
            end else begin
                remove_card();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
